// File: rtl/grav_bridge_pkg.sv
// Shared state encodings, status-word bit positions and constants for the
// gravity-core PIO bridge.
package grav_bridge_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_HOLD = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_WRITE   = ST_WRITE,
        S_RD_WAIT = ST_RD_WAIT,
        S_RD_HOLD = ST_RD_HOLD,
        S_RUN     = ST_RUN
    } state_e;

    localparam int STAT_WCNT_LSB  = 16;
    localparam int STAT_ERR_RANGE = 7;
    localparam int STAT_ERR_BUSY  = 6;
    localparam int STAT_STATE_LSB = 3;
    localparam int STAT_DONE      = 0;

    localparam logic [15:0] WR_CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/grav_pio_bridge_if.sv
// Host PIO and core-side signal bundle for grav_pio_bridge.
// The bridge uses the slave modport; the surrounding system uses master.
interface grav_pio_bridge_if #(
    parameter int ADDR_LEN = 12,
    parameter int DATA_W   = 32,
    parameter int NUM_CH   = 2
);
    logic [ADDR_LEN-1:0]        host_index;
    logic                       host_we;
    logic                       host_send;
    logic                       host_rd_req;
    logic [ADDR_LEN-1:0]        host_obj_count;
    logic [NUM_CH*DATA_W-1:0]   host_pos_data;
    logic [DATA_W-1:0]          host_mass_data;
    logic [NUM_CH*DATA_W-1:0]   host_rd_data;
    logic                       host_rd_valid;
    logic [31:0]                host_status;

    logic                       acc_pos_we;
    logic [ADDR_LEN-1:0]        acc_pos_addr;
    logic [NUM_CH*DATA_W-1:0]   acc_pos_data;
    logic [DATA_W-1:0]          acc_mass_data;
    logic [ADDR_LEN-1:0]        acc_num_objects;
    logic                       acc_sending;
    logic [ADDR_LEN-1:0]        acc_accel_addr;
    logic [NUM_CH*DATA_W-1:0]   acc_accel_data;
    logic                       acc_done;

    modport slave (
        input  host_index, host_we, host_send, host_rd_req, host_obj_count,
               host_pos_data, host_mass_data, acc_accel_data, acc_done,
        output host_rd_data, host_rd_valid, host_status, acc_pos_we,
               acc_pos_addr, acc_pos_data, acc_mass_data, acc_num_objects,
               acc_sending, acc_accel_addr
    );

    modport master (
        output host_index, host_we, host_send, host_rd_req, host_obj_count,
               host_pos_data, host_mass_data, acc_accel_data, acc_done,
        input  host_rd_data, host_rd_valid, host_status, acc_pos_we,
               acc_pos_addr, acc_pos_data, acc_mass_data, acc_num_objects,
               acc_sending, acc_accel_addr
    );

endinterface

// File: rtl/grav_edge_sync.sv
// Command input conditioner: optional two-flop synchronizer (GRAV_BRIDGE_SYNC_EN)
// followed by a rising-edge detector on the conditioned level.
module grav_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic level_q;
    logic level_d;

`ifdef GRAV_BRIDGE_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], din};

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign level = sync_q[1];
`else
    assign level = din;
`endif

    always_comb level_d = level;

    always_ff @(posedge clk) begin
        if (reset) level_q <= 1'b0;
        else       level_q <= level_d;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/grav_pio_bridge.sv
// Sequencer between HPS PIO registers and the gravity acceleration core:
// write strobes, latency-aware readback, run control, sticky errors, status word.
// Build option GRAV_BRIDGE_SYNC_EN synchronizes host_we/host_send/host_rd_req.
module grav_pio_bridge
    import grav_bridge_pkg::*;
#(
    parameter int          ADDR_LEN    = 12,
    parameter int          DATA_W      = 32,
    parameter int          NUM_CH      = 2,
    parameter int          RD_LATENCY  = 2,
    parameter int unsigned MAX_OBJECTS = 4095
) (
    input logic               clk,
    input logic               reset,
    grav_pio_bridge_if.slave  bus
);

    localparam int W = NUM_CH * DATA_W;
    localparam logic [ADDR_LEN-1:0] MAX_COUNT = ADDR_LEN'(MAX_OBJECTS);

    logic we_lvl, we_rise, send_lvl, send_rise, rd_lvl, rd_rise;
    logic unused_sync;

    grav_edge_sync u_we_sync   (.clk(clk), .reset(reset), .din(bus.host_we),
                                .level(we_lvl),   .rise(we_rise));
    grav_edge_sync u_send_sync (.clk(clk), .reset(reset), .din(bus.host_send),
                                .level(send_lvl), .rise(send_rise));
    grav_edge_sync u_rd_sync   (.clk(clk), .reset(reset), .din(bus.host_rd_req),
                                .level(rd_lvl),   .rise(rd_rise));

    assign unused_sync = &{we_lvl, send_rise, rd_rise};

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] pos_addr_q, pos_addr_d;
    logic [W-1:0]        pos_data_q, pos_data_d;
    logic [DATA_W-1:0]   mass_q, mass_d;
    logic [ADDR_LEN-1:0] num_obj_q, num_obj_d;
    logic [ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
    logic [W-1:0]        rd_data_q, rd_data_d;
    logic [2:0]          lat_cnt_q, lat_cnt_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;
    logic pos_we_q, pos_we_d, sending_q, sending_d, rd_valid_q, rd_valid_d;
    logic rd_served_q, rd_served_d, err_range_q, err_range_d;
    logic err_busy_q, err_busy_d, done_q, done_d;
    logic                cmd_rd;
    logic [ADDR_LEN-1:0] obj_clamped;
    logic [31:0]         status;

    always_comb begin
        obj_clamped = bus.host_obj_count;
        if (32'(bus.host_obj_count) > MAX_OBJECTS) obj_clamped = MAX_COUNT;
    end

    // Priority in IDLE is write edge, then read, then run; the object count
    // only follows the host when none of those is being accepted.
    always_comb begin
        state_d     = state_q;
        pos_addr_d  = pos_addr_q;
        pos_data_d  = pos_data_q;
        mass_d      = mass_q;
        num_obj_d   = num_obj_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        lat_cnt_d   = lat_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        pos_we_d    = 1'b0;
        rd_valid_d  = rd_valid_q;
        rd_served_d = rd_served_q & rd_lvl;
        err_range_d = err_range_q;
        err_busy_d  = err_busy_q | (we_rise & (state_q != S_IDLE));
        done_d      = done_q;
        cmd_rd      = rd_lvl & ~rd_served_q;

        unique case (state_q)
            S_IDLE: begin
                if (we_rise) begin
                    if (bus.host_index < num_obj_q) begin
                        pos_addr_d = bus.host_index;
                        pos_data_d = bus.host_pos_data;
                        mass_d     = bus.host_mass_data;
                        state_d    = S_WRITE;
                    end else begin
                        err_range_d = 1'b1;
                    end
                end else if (cmd_rd) begin
                    // Address goes out this cycle, so this cycle counts as the first latency cycle.
                    rd_addr_d   = bus.host_index;
                    lat_cnt_d   = 3'd1;
                    rd_served_d = 1'b1;
                    state_d     = S_RD_WAIT;
                end else if (send_lvl) begin
                    done_d  = 1'b0;
                    state_d = S_RUN;
                end else begin
                    num_obj_d = obj_clamped;
                end
            end
            S_WRITE: begin
                pos_we_d = 1'b1;
                if (wr_cnt_q != WR_CNT_SAT) wr_cnt_d = wr_cnt_q + 16'd1;
                state_d = S_IDLE;
            end
            S_RD_WAIT: begin
                if (lat_cnt_q == 3'(RD_LATENCY)) begin
                    rd_data_d  = bus.acc_accel_data;
                    rd_valid_d = 1'b1;
                    state_d    = S_RD_HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            S_RD_HOLD: begin
                if (!rd_lvl) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.acc_done) done_d = 1'b1;
                if (!send_lvl) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        sending_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pos_addr_q  <= '0;
            pos_data_q  <= '0;
            mass_q      <= '0;
            num_obj_q   <= '0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            lat_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            pos_we_q    <= 1'b0;
            sending_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_served_q <= 1'b0;
            err_range_q <= 1'b0;
            err_busy_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_addr_q  <= pos_addr_d;
            pos_data_q  <= pos_data_d;
            mass_q      <= mass_d;
            num_obj_q   <= num_obj_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            lat_cnt_q   <= lat_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            pos_we_q    <= pos_we_d;
            sending_q   <= sending_d;
            rd_valid_q  <= rd_valid_d;
            rd_served_q <= rd_served_d;
            err_range_q <= err_range_d;
            err_busy_q  <= err_busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        status                          = '0;
        status[STAT_WCNT_LSB +: 16]     = wr_cnt_q;
        status[STAT_ERR_RANGE]          = err_range_q;
        status[STAT_ERR_BUSY]           = err_busy_q;
        status[STAT_STATE_LSB +: 3]     = state_q;
        status[STAT_DONE]               = done_q;
    end

    assign bus.host_rd_data    = rd_data_q;
    assign bus.host_rd_valid   = rd_valid_q;
    assign bus.host_status     = status;
    assign bus.acc_pos_we      = pos_we_q;
    assign bus.acc_pos_addr    = pos_addr_q;
    assign bus.acc_pos_data    = pos_data_q;
    assign bus.acc_mass_data   = mass_q;
    assign bus.acc_num_objects = num_obj_q;
    assign bus.acc_sending     = sending_q;
    assign bus.acc_accel_addr  = rd_addr_d;

endmodule

// File: tb/tb_grav_pio_bridge.sv
// Scoreboard bench for grav_pio_bridge: directed host commands push expected
// core writes and readbacks into queues that a negedge monitor drains.
module tb_grav_pio_bridge;

    localparam int ADDR_LEN = 13;
    localparam int DATA_W   = 32;
    localparam int NUM_CH   = 2;
    localparam int RD_LAT   = 2;
    localparam int W        = NUM_CH * DATA_W;
`ifdef GRAV_BRIDGE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [W-1:0]        data;
        logic [DATA_W-1:0]   mass;
    } wr_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    wr_exp_t      wr_q[$];
    logic [W-1:0] rd_q[$];
    wr_exp_t      wr_e;
    logic [W-1:0] rd_e;
    logic         rd_valid_prev;
    logic [W-1:0] core_pipe [RD_LAT];

    grav_pio_bridge_if #(.ADDR_LEN(ADDR_LEN), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    grav_pio_bridge #(
        .ADDR_LEN(ADDR_LEN), .DATA_W(DATA_W), .NUM_CH(NUM_CH),
        .RD_LATENCY(RD_LAT), .MAX_OBJECTS(4095)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Core acceleration memory model: fixed contents, RD_LAT-cycle read pipeline.
    function automatic logic [W-1:0] core_word(input logic [ADDR_LEN-1:0] a);
        if (a == 13'd5) return {32'h0000_1234, 32'hFFFF_0000};
        return {32'h0000_0100 + 32'(a), 32'hA5A5_0000 | 32'(a)};
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= core_word(bus.acc_accel_addr);
        for (int i = 1; i < RD_LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end

    assign bus.acc_accel_data = core_pipe[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_LEN-1:0] idx, input logic we,
                                 input logic rd, input logic send);
        @(posedge clk);
        #1;
        bus.host_index  = idx;
        bus.host_we     = we;
        bus.host_rd_req = rd;
        bus.host_send   = send;
    endtask

    // Monitor: every core write pulse and every rising read-valid consumes one expectation.
    always @(negedge clk) begin
        if (reset) begin
            rd_valid_prev = 1'b0;
        end else begin
            if (bus.acc_pos_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got pulse at addr %0h expected none",
                             bus.acc_pos_addr);
                end else begin
                    wr_e = wr_q.pop_front();
                    checkOutput("wr_addr", W'(bus.acc_pos_addr), W'(wr_e.addr));
                    checkOutput("wr_data", bus.acc_pos_data, wr_e.data);
                    checkOutput("wr_mass", W'(bus.acc_mass_data), W'(wr_e.mass));
                end
            end
            if (bus.host_rd_valid && !rd_valid_prev) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_read: got data %0h expected none",
                             bus.host_rd_data);
                end else begin
                    rd_e = rd_q.pop_front();
                    checkOutput("rd_data", bus.host_rd_data, rd_e);
                end
            end
            rd_valid_prev = bus.host_rd_valid;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        bus.host_index     = '0;
        bus.host_we        = 1'b0;
        bus.host_send      = 1'b0;
        bus.host_rd_req    = 1'b0;
        bus.host_obj_count = '0;
        bus.host_pos_data  = '0;
        bus.host_mass_data = '0;
        bus.acc_done       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_status",   W'(bus.host_status),     '0);
        checkOutput("reset_pos_we",   W'(bus.acc_pos_we),      '0);
        checkOutput("reset_rd_valid", W'(bus.host_rd_valid),   '0);
        checkOutput("reset_sending",  W'(bus.acc_sending),     '0);
        checkOutput("reset_num_obj",  W'(bus.acc_num_objects), '0);

        @(posedge clk);
        #1;
        reset              = 1'b0;
        bus.host_obj_count = 13'd10;
        repeat (3) @(negedge clk);
        checkOutput("num_obj_10", W'(bus.acc_num_objects), 64'd10);

        // In-range write: one pulse exactly two clocks after the edge.
        bus.host_pos_data  = {32'h0002_0000, 32'h0001_0000};
        bus.host_mass_data = 32'h0000_8000;
        wr_q.push_back('{addr: 13'd3, data: {32'h0002_0000, 32'h0001_0000}, mass: 32'h0000_8000});
        applyStimulus(13'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 4 + SYNC; k++) begin
            @(negedge clk);
            checkOutput($sformatf("wr_pulse_k%0d", k), W'(bus.acc_pos_we), W'(k == 2 + SYNC));
        end
        checkOutput("wr_count_1", W'(bus.host_status[31:16]), 64'd1);
        applyStimulus(13'd3, 1'b0, 1'b0, 1'b0);
        repeat (2 + SYNC) @(negedge clk);

        // Out-of-range write: no pulse, range error, count unchanged.
        applyStimulus(13'd10, 1'b1, 1'b0, 1'b0);
        repeat (4 + SYNC) @(negedge clk);
        checkOutput("err_range_set", W'(bus.host_status[7]),     64'd1);
        checkOutput("wr_count_hold", W'(bus.host_status[31:16]), 64'd1);
        checkOutput("err_busy_clr",  W'(bus.host_status[6]),     64'd0);
        applyStimulus(13'd10, 1'b0, 1'b0, 1'b0);
        repeat (2 + SYNC) @(negedge clk);

        // Readback of index 5: valid three cycles after request, held until release.
        rd_q.push_back({32'h0000_1234, 32'hFFFF_0000});
        applyStimulus(13'd5, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k <= 5 + SYNC; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rd_valid_k%0d", k), W'(bus.host_rd_valid), W'(k >= 3 + SYNC));
        end
        repeat (3) @(negedge clk);
        checkOutput("rd_hold_state", W'(bus.host_status[5:3]), 64'd3);
        checkOutput("rd_hold_valid", W'(bus.host_rd_valid),     64'd1);
        applyStimulus(13'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rd_release_k0", W'(bus.host_rd_valid), 64'd1);
        repeat (1 + SYNC) @(negedge clk);
        checkOutput("rd_release_clr", W'(bus.host_rd_valid),     64'd0);
        checkOutput("rd_data_kept",   bus.host_rd_data,          {32'h0000_1234, 32'hFFFF_0000});
        checkOutput("rd_idle_state",  W'(bus.host_status[5:3]), 64'd0);

        // Write edge and read request together: write first, read issued right after WRITE.
        bus.host_pos_data  = {32'hDEAD_0001, 32'h0000_BEEF};
        bus.host_mass_data = 32'h0001_0000;
        wr_q.push_back('{addr: 13'd4, data: {32'hDEAD_0001, 32'h0000_BEEF}, mass: 32'h0001_0000});
        rd_q.push_back({32'h0000_0104, 32'hA5A5_0004});
        applyStimulus(13'd4, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= 5 + SYNC; k++) begin
            @(negedge clk);
            if (k == 1 + SYNC) checkOutput("both_write_state", W'(bus.host_status[5:3]), 64'd1);
            if (k == 2 + SYNC) begin
                checkOutput("both_pos_we",   W'(bus.acc_pos_we),     64'd1);
                checkOutput("both_rd_addr",  W'(bus.acc_accel_addr), 64'd4);
            end
            if (k == 3 + SYNC) checkOutput("both_rdwait_state", W'(bus.host_status[5:3]), 64'd2);
            if (k == 4 + SYNC) checkOutput("both_valid_early",  W'(bus.host_rd_valid),   64'd0);
            if (k == 5 + SYNC) checkOutput("both_valid",        W'(bus.host_rd_valid),   64'd1);
        end
        applyStimulus(13'd4, 1'b0, 1'b0, 1'b0);
        repeat (3 + SYNC) @(negedge clk);
        checkOutput("both_idle",    W'(bus.host_status[5:3]),   64'd0);
        checkOutput("wr_count_2",   W'(bus.host_status[31:16]), 64'd2);

        // Run: busy error on write edge, done latch, exit on send drop.
        applyStimulus(13'd4, 1'b0, 1'b0, 1'b1);
        repeat (2 + SYNC) @(negedge clk);
        checkOutput("run_sending",   W'(bus.acc_sending),       64'd1);
        checkOutput("run_state",     W'(bus.host_status[5:3]), 64'd4);
        checkOutput("run_done_clr",  W'(bus.host_status[0]),   64'd0);
        applyStimulus(13'd4, 1'b1, 1'b0, 1'b1);
        repeat (2 + SYNC) @(negedge clk);
        checkOutput("run_err_busy",  W'(bus.host_status[6]),   64'd1);
        checkOutput("run_state_hold", W'(bus.host_status[5:3]), 64'd4);
        @(posedge clk);
        #1 bus.acc_done = 1'b1;
        @(posedge clk);
        #1 bus.acc_done = 1'b0;
        @(negedge clk);
        checkOutput("run_done_set",  W'(bus.host_status[0]),   64'd1);
        applyStimulus(13'd4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("run_exit_k0",   W'(bus.acc_sending),       64'd1);
        repeat (1 + SYNC) @(negedge clk);
        checkOutput("run_exit_send", W'(bus.acc_sending),       64'd0);
        checkOutput("run_exit_state", W'(bus.host_status[5:3]), 64'd0);
        checkOutput("run_done_kept", W'(bus.host_status[0]),   64'd1);
        checkOutput("run_busy_kept", W'(bus.host_status[6]),   64'd1);

        // Reset in the middle of a read aborts it; object count clamps afterwards.
        applyStimulus(13'd2, 1'b0, 1'b1, 1'b0);
        repeat (2 + SYNC) @(negedge clk);
        checkOutput("abort_rdwait", W'(bus.host_status[5:3]), 64'd2);
        @(posedge clk);
        #1;
        reset              = 1'b1;
        bus.host_rd_req    = 1'b0;
        bus.host_obj_count = 13'd5000;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_rd_valid", W'(bus.host_rd_valid), 64'd0);
        checkOutput("abort_status",   W'(bus.host_status),   64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("clamp_num_obj",  W'(bus.acc_num_objects), 64'd4095);
        checkOutput("abort_no_valid", W'(bus.host_rd_valid),   64'd0);

        repeat (4) @(negedge clk);
        checkOutput("wr_queue_empty", W'(wr_q.size()), 64'd0);
        checkOutput("rd_queue_empty", W'(rd_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grav_pio_bridge.md
Name: grav_pio_bridge

Overview:
Sequencer between the HPS-facing PIO registers and the gravity acceleration core (city) on accel_clk.
- Replaces ad-hoc level wiring with edge-detected write strobes, a four-phase readback handshake that honours M10K read latency, and run control.
- Adds sticky error flags and a status word.
- Generalised to NUM_CH position/acceleration channels (2 = x,y; 3 = x,y,z).

Parameters:
ADDR_LEN, 12, object index width
DATA_W, 32, width of one channel word (fixed-point)
NUM_CH, 2, spatial channels per object (2 or 3)
RD_LATENCY, 2, cycles from acc_accel_addr valid to acc_accel_data valid (1..7)
MAX_OBJECTS, 4095, clamp value for the object count

Ports:
clk  in  1  accel clock
reset  in  1  synchronous, active-high
host_index  in  ADDR_LEN  object index for write or read
host_we  in  1  write request level; the rising edge is the command
host_send  in  1  run request level
host_rd_req  in  1  read request, four-phase
host_obj_count  in  ADDR_LEN  number of objects
host_pos_data  in  NUM_CH*DATA_W  position words, channel 0 in LSBs
host_mass_data  in  DATA_W  mass word
host_rd_data  out  NUM_CH*DATA_W  captured acceleration words
host_rd_valid  out  1  read data valid
host_status  out  32  status word
acc_pos_we  out  1  one-cycle write pulse to core
acc_pos_addr  out  ADDR_LEN  write address
acc_pos_data  out  NUM_CH*DATA_W  registered position data
acc_mass_data  out  DATA_W  registered mass
acc_num_objects  out  ADDR_LEN  registered, clamped object count
acc_sending  out  1  run enable to core
acc_accel_addr  out  ADDR_LEN  acceleration read address
acc_accel_data  in  NUM_CH*DATA_W  acceleration read data from core
acc_done  in  1  core finished pass

Behaviour:
- Reset: all outputs, write count, error flags and done_latched go to 0; state goes to IDLE. A reset mid-operation aborts any pending read or run the same cycle.
- FSM states and encodings: IDLE=0, WRITE=1, RD_WAIT=2, RD_HOLD=3, RUN=4.
- Edge detection: we_q is host_we delayed one cycle. A rising edge is host_we & ~we_q.
- Write path (in IDLE):
  - Rising edge with host_index < acc_num_objects → latch addr/data/mass, go to WRITE.
  - In WRITE: acc_pos_we=1 for exactly one cycle, then IDLE. Write latency is 2 cycles from the edge.
  - Write count increments and saturates at 0xFFFF.
  - host_index >= acc_num_objects → no pulse; set err_range.
- Write outside IDLE: the edge is dropped and err_busy is set.
- Object count: acc_num_objects <= min(host_obj_count, MAX_OBJECTS). It updates only in IDLE, and only on cycles with no command.
- Read path:
  - Entry: IDLE, host_rd_req=1, rd_served=0, and no write edge this cycle → drive acc_accel_addr=host_index, go to RD_WAIT.
  - RD_WAIT: count RD_LATENCY cycles, then capture acc_accel_data into host_rd_data and go to RD_HOLD with host_rd_valid=1.
  - RD_HOLD: hold until host_rd_req=0, then clear host_rd_valid, go to IDLE.
  - rd_served prevents re-issuing a read while the request stays high.
  - host_rd_data keeps its last value until the next capture.
- Simultaneous write edge and rd_req in IDLE: write wins. The read starts the cycle after WRITE because the request is a level.
- Run:
  - Entry: IDLE with host_send=1 and no other command → RUN. acc_sending=1 and done_latched is cleared.
  - acc_done=1 in RUN sets done_latched.
  - host_send=0 exits to IDLE with acc_sending=0 the next cycle, whether or not the core is done.
  - Read requests during RUN wait in IDLE-entry order. They are not errors.
- host_status bit fields:
  - [31:16] write count
  - [15:8] 0
  - [7] err_range
  - [6] err_busy
  - [5:3] state
  - [2:1] 0
  - [0] done_latched
- Errors are sticky until reset.

Optional Feature:
GRAV_BRIDGE_SYNC_EN:
- Defined: host_we, host_send and host_rd_req each pass through a two-flop synchronizer before edge and level detection. All command latencies grow by 2 cycles.
- Undefined: inputs are used directly, because the PIOs are on clk.

Decomposition:
- Package grav_bridge_pkg holds:
  - the state enum typedef
  - status bit-position constants
  - the saturation constant 16'hFFFF
- Sub-module grav_edge_sync: optional synchronizer plus rising-edge detector, instantiated three times.

Test Plan:
- Reset, obj_count=10, index=3, pos x=32'h0001_0000, y=32'h0002_0000, mass=32'h0000_8000, pulse we → one acc_pos_we cycle 2 clocks after the edge; addr=3, data matches; status[31:16]=1.
- obj_count=10, index=10, we edge → no acc_pos_we; status[7]=1; write count unchanged.
- RD_LATENCY=2, index=5, rd_req high, core returns x=32'hFFFF_0000, y=32'h0000_1234 → rd_valid high 3 cycles after the request, data matches; valid stays high; no re-read until rd_req drops; valid clears 1 cycle after the drop.
- Write edge and rd_req in the same cycle → write pulse first; the read issues in the cycle after WRITE.
- send=1, we edge during RUN → status[6]=1; acc_done pulse → status[0]=1; send=0 → acc_sending=0 next cycle, state=IDLE.
- Reset asserted in RD_WAIT → rd_valid=0, state=IDLE, status=0 next cycle; obj_count=5000 after reset → acc_num_objects=4095.
